// File: rtl/nfc_ask_demod.sv
// -----------------------------------------------------------------------------
// nfc_ask_demod
//
// Recovers the modulating bit stream from a sampled, amplitude-modulated
// 13.56 MHz carrier. The sample is rectified, peak-detected over fixed
// windows of WINDOW clocks, sliced with hysteresis and debounced over
// DEBOUNCE windows. Each accepted level change is reported with a one-cycle
// strobe and the number of windows the previous level lasted.
//
// Ports:
//   clk        emulation clock, one input sample per cycle
//   rst        asynchronous, active-low reset
//   v_in       signed channel sample (two's complement, WIDTH bits)
//   env        peak magnitude of the last completed window (MSB always 0)
//   env_valid  high once the first window has completed (FSM in TRACK)
//   out_bit    debounced recovered envelope bit
//   edge_stb   one-cycle pulse on every out_bit change
//   dur        windows the previous out_bit level lasted; updated with edge_stb
//
// Handshake: there is no backpressure. edge_stb is high for exactly one clock
// and dur is stable from that clock until the next edge; a consumer must
// sample edge_stb in the cycle it is high.
// -----------------------------------------------------------------------------
module nfc_ask_demod #(
    parameter int WIDTH     = 25,
    parameter int WINDOW    = 64,
    parameter int THRESH_HI = 4600,
    parameter int THRESH_LO = 4400,
    parameter int DEBOUNCE  = 2,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] v_in,
    output logic        [WIDTH-1:0] env,
    output logic                    env_valid,
    output logic                    out_bit,
    output logic                    edge_stb,
    output logic        [CNT_W-1:0] dur
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE + 1);
    localparam int SUM_W = CNT_W + 1;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WIDTH-1:0] MAG_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] TH_HI    = WIDTH'(THRESH_HI);
    localparam logic [WIDTH-1:0] TH_LO    = WIDTH'(THRESH_LO);
    localparam logic [DEB_W-1:0] DEB_TGT  = DEB_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] DUR_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] DUR_RST  = CNT_W'(DEBOUNCE);

    // FSM encoding
    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [WIN_W-1:0] r_win_cnt;
    logic [WIDTH-1:0] r_run_max;
    logic [WIDTH-1:0] r_env;
    logic             r_win_done;
    logic             r_slice;
    logic             r_out_bit;
    logic             r_edge_stb;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [CNT_W-1:0] r_dur_cnt;
    logic [CNT_W-1:0] r_dur;

    // -------------------------------------------------------------------------
    // Rectifier
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] w_raw;
    logic             w_neg;
    logic             w_neg_min;
    logic [WIDTH-1:0] w_mag;

    assign w_raw     = v_in;
    assign w_neg     = w_raw[WIDTH-1];
    // The most-negative code has no positive counterpart; clamp it.
    assign w_neg_min = w_neg && (w_raw[WIDTH-2:0] == '0);

    always_comb begin
        w_mag = w_raw;
        if (w_neg_min) begin
            w_mag = MAG_MAX;
        end else if (w_neg) begin
            w_mag = ~w_raw + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Peak detector window
    // -------------------------------------------------------------------------
    logic             w_last;
    logic [WIDTH-1:0] w_peak;

    assign w_last = (r_win_cnt == WIN_LAST);
    // Peak includes the current sample so env reflects all WINDOW samples.
    assign w_peak = (w_mag > r_run_max) ? w_mag : r_run_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_cnt  <= '0;
            r_run_max  <= '0;
            r_env      <= '0;
            r_win_done <= 1'b0;
            r_state    <= ST_FILL;
        end else begin
            r_win_done <= w_last;
            if (w_last) begin
                r_win_cnt <= '0;
                r_run_max <= '0;
                r_env     <= w_peak;
                if (r_state == ST_FILL) begin
                    r_state <= ST_TRACK;
                end
            end else begin
                r_win_cnt <= r_win_cnt + 1'b1;
                r_run_max <= w_peak;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Slicer, debounce and duration tracking
    // -------------------------------------------------------------------------
    logic             w_eval;
    logic             w_slice;
    logic             w_differ;
    logic [DEB_W-1:0] w_deb_next;
    logic             w_toggle;
    logic [SUM_W-1:0] w_dur_sum;
    logic [CNT_W-1:0] w_dur_sat;

    // Evaluate once per window, the cycle after env was latched.
    assign w_eval = r_win_done && (r_state == ST_TRACK);

    always_comb begin
        w_slice = r_slice;
        if (r_env >= TH_HI) begin
            w_slice = 1'b1;
        end else if (r_env <= TH_LO) begin
            w_slice = 1'b0;
        end
    end

    assign w_differ   = (w_slice != r_out_bit);
    assign w_deb_next = r_deb_cnt + 1'b1;
    assign w_toggle   = w_eval && w_differ && (w_deb_next == DEB_TGT);

    // Windows spent in a pending (disagreeing) run are held back from
    // dur_cnt. If the run is accepted they belong to the new level, which is
    // why dur_cnt restarts at DEBOUNCE; if the run is rejected as a glitch
    // they are credited back to the current level here, together with the
    // window being evaluated. This keeps dur equal to the real length of the
    // previous level, glitches included.
    assign w_dur_sum = {1'b0, r_dur_cnt} + SUM_W'(r_deb_cnt) + SUM_W'(1);
    assign w_dur_sat = w_dur_sum[CNT_W] ? DUR_MAX : w_dur_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slice    <= 1'b0;
            r_out_bit  <= 1'b0;
            r_edge_stb <= 1'b0;
            r_deb_cnt  <= '0;
            r_dur_cnt  <= '0;
            r_dur      <= '0;
        end else begin
            r_edge_stb <= w_toggle;
            if (w_eval) begin
                r_slice <= w_slice;
                if (w_toggle) begin
                    r_out_bit <= ~r_out_bit;
                    r_dur     <= r_dur_cnt;
                    r_dur_cnt <= DUR_RST;
                    r_deb_cnt <= '0;
                end else if (w_differ) begin
                    r_deb_cnt <= w_deb_next;
                end else begin
                    r_deb_cnt <= '0;
                    r_dur_cnt <= w_dur_sat;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign env       = r_env;
    assign env_valid = (r_state == ST_TRACK);
    assign out_bit   = r_out_bit;
    assign edge_stb  = r_edge_stb;
    assign dur       = r_dur;

endmodule

// File: tb/tb_nfc_ask_demod.sv
// -----------------------------------------------------------------------------
// tb_nfc_ask_demod
//
// Drives nfc_ask_demod with directed carrier sequences and random envelopes
// and compares every output, every cycle, against a window-level reference
// model. Directed phases also carry hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_nfc_ask_demod;

    localparam int W     = 25;
    localparam int WIN   = 64;
    localparam int TH_HI = 4600;
    localparam int TH_LO = 4400;
    localparam int DEB   = 2;
    localparam int CW    = 16;
    localparam longint MAG_MAX = (longint'(1) << (W - 1)) - 1;
    localparam longint DUR_MAX = (longint'(1) << CW) - 1;

    // -------------------------------------------------------------------------
    // Clock / reset / DUT
    // -------------------------------------------------------------------------
    logic                clk;
    logic                rst;
    logic signed [W-1:0] v_in;
    logic [W-1:0]        env;
    logic                env_valid;
    logic                out_bit;
    logic                edge_stb;
    logic [CW-1:0]       dur;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nfc_ask_demod #(
        .WIDTH    (W),
        .WINDOW   (WIN),
        .THRESH_HI(TH_HI),
        .THRESH_LO(TH_LO),
        .DEBOUNCE (DEB),
        .CNT_W    (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .v_in     (v_in),
        .env      (env),
        .env_valid(env_valid),
        .out_bit  (out_bit),
        .edge_stb (edge_stb),
        .dur      (dur)
    );

    // -------------------------------------------------------------------------
    // Scoreboard counters
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_err    = 0;

    function automatic void check(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // -------------------------------------------------------------------------
    // Reference model: per-sample peak, per-window slice history, and level
    // start indices. dur is the distance between consecutive level starts.
    // -------------------------------------------------------------------------
    int     m_pos;
    longint m_max;
    longint m_env;
    bit     m_valid;
    bit     m_pend;
    bit     m_slice;
    bit     m_out;
    bit     m_edge;
    longint m_dur;
    int     m_nwin;
    int     m_start;
    bit     hist[1024];

    function automatic void model_reset();
        m_pos = 0; m_max = 0; m_env = 0; m_valid = 0; m_pend = 0;
        m_slice = 0; m_out = 0; m_edge = 0; m_dur = 0;
        m_nwin = 0; m_start = 0;
    endfunction

    function automatic void model_eval();
        bit     all_diff;
        int     ns;
        longint d;
        if (m_env >= TH_HI) m_slice = 1;
        else if (m_env <= TH_LO) m_slice = 0;
        hist[m_nwin % 1024] = m_slice;
        all_diff = (m_nwin + 1 >= DEB);
        for (int k = 0; k < DEB; k++) begin
            if (m_nwin - k >= 0 && hist[(m_nwin - k) % 1024] == m_out) all_diff = 0;
        end
        if (all_diff) begin
            m_out  = !m_out;
            m_edge = 1;
            ns     = m_nwin - DEB + 1;
            d      = ns - m_start;
            if (d > DUR_MAX) d = DUR_MAX;
            m_dur   = d;
            m_start = ns;
        end
        m_nwin++;
    endfunction

    function automatic void model_step(longint v);
        longint mag;
        if (!rst) begin
            model_reset();
            return;
        end
        m_edge = 0;
        if (m_pend) begin
            model_eval();
            m_pend = 0;
        end
        mag = (v < 0) ? -v : v;
        if (mag > MAG_MAX) mag = MAG_MAX;
        if (mag > m_max) m_max = mag;
        m_pos++;
        if (m_pos == WIN) begin
            m_env   = m_max;
            m_max   = 0;
            m_pos   = 0;
            m_valid = 1;
            m_pend  = 1;
        end
    endfunction

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    int row_edges = 0;
    int row_dur   = 0;
    int pend_row  = -1;

    typedef struct {
        int amp;
        int nwin;
        bit exp_out;
        int exp_edges;
        int exp_dur;   // -1: not checked
    } row_t;

    row_t rows[13];

    task automatic cycle(input longint val);
        v_in = W'(val);
        @(posedge clk);
        model_step(longint'(v_in));
        #1;
        check("env",       longint'(env),       m_env);
        check("env_valid", longint'(env_valid), longint'(m_valid));
        check("out_bit",   longint'(out_bit),   longint'(m_out));
        check("edge_stb",  longint'(edge_stb),  longint'(m_edge));
        check("dur",       longint'(dur),       m_dur);
        if (edge_stb) begin
            row_edges++;
            row_dur = int'(dur);
        end
    endtask

    task automatic check_row(input int r);
        check($sformatf("row%0d_out", r),   longint'(out_bit), longint'(rows[r].exp_out));
        check($sformatf("row%0d_edges", r), row_edges,         rows[r].exp_edges);
        if (rows[r].exp_dur >= 0)
            check($sformatf("row%0d_dur", r), row_dur, rows[r].exp_dur);
        row_edges = 0;
    endtask

    // Square carrier of amplitude amp with an optional single spike sample.
    task automatic run_window(input int amp, input int spike_pos, input longint spike_val);
        longint v;
        for (int i = 0; i < WIN; i++) begin
            v = (i == spike_pos) ? spike_val : ((i % 2 == 0) ? longint'(amp) : -longint'(amp));
            cycle(v);
            if (i == 0 && pend_row >= 0) begin
                check_row(pend_row);
                pend_row = -1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) cycle(0);
        rst = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Test sequence
    // -------------------------------------------------------------------------
    initial begin
        rows[0]  = '{4500,  3, 1'b0, 0, -1};  // inside band from reset: no change
        rows[1]  = '{5000, 10, 1'b1, 1,  3};
        rows[2]  = '{4000, 10, 1'b0, 1, 10};
        rows[3]  = '{5000, 10, 1'b1, 1, 10};
        rows[4]  = '{4000, 10, 1'b0, 1, 10};
        rows[5]  = '{5000, 10, 1'b1, 1, 10};
        rows[6]  = '{4500,  6, 1'b1, 0, -1};  // hysteresis band holds high
        rows[7]  = '{4300,  1, 1'b1, 0, -1};
        rows[8]  = '{4300,  1, 1'b0, 1, 16};  // falls on 2nd low window
        rows[9]  = '{5000,  6, 1'b1, 1,  2};
        rows[10] = '{4000,  1, 1'b1, 0, -1};  // single-window glitch
        rows[11] = '{5000,  8, 1'b1, 0, -1};
        rows[12] = '{4000,  2, 1'b0, 1, 15};  // dur spans the glitch

        model_reset();
        v_in = '0;
        rst  = 1'b0;
        #2;
        check("rst_env",       longint'(env),       0);
        check("rst_env_valid", longint'(env_valid), 0);
        check("rst_out_bit",   longint'(out_bit),   0);
        check("rst_edge_stb",  longint'(edge_stb),  0);
        check("rst_dur",       longint'(dur),       0);
        do_reset(5);

        // Fill with constant 1000.
        for (int i = 0; i < WIN; i++) begin
            cycle(1000);
            if (i < WIN - 1) begin
                check("fill_valid_lo", longint'(env_valid), 0);
            end else begin
                check("fill_valid_hi", longint'(env_valid), 1);
                check("fill_env",      longint'(env),       1000);
            end
        end
        row_edges = 0;
        run_window(1000, -1, 0);
        run_window(1000, -1, 0);
        check("fill_out_bit", longint'(out_bit), 0);
        check("fill_no_edge", row_edges, 0);

        // Rectify and peak.
        run_window(5000, 30, -5200);
        check("peak_spike", longint'(env), 5200);
        run_window(5000, -1, 0);
        check("peak_next", longint'(env), 5000);
        run_window(5000, 17, -(longint'(1) << 24));
        check("rect_sat", longint'(env), (longint'(1) << 24) - 1);
        run_window(5000, -1, 0);
        check("peak_after_sat", longint'(env), 5000);

        // Table-driven modulation / hysteresis / glitch phases from reset.
        do_reset(3);
        row_edges = 0;
        pend_row  = -1;
        for (int r = 0; r < 13; r++) begin
            for (int w = 0; w < rows[r].nwin; w++) run_window(rows[r].amp, -1, 0);
            pend_row = r;
        end
        run_window(4000, -1, 0);

        // Reset mid-debounce while out_bit is high.
        run_window(5000, -1, 0);
        run_window(5000, -1, 0);
        run_window(5000, -1, 0);
        run_window(4000, -1, 0);
        for (int i = 0; i < 10; i++) cycle((i % 2 == 0) ? 5000 : -5000);
        check("pre_rst_out_bit", longint'(out_bit), 1);
        #2 rst = 1'b0;
        #1;
        check("async_env",       longint'(env),       0);
        check("async_env_valid", longint'(env_valid), 0);
        check("async_out_bit",   longint'(out_bit),   0);
        check("async_edge_stb",  longint'(edge_stb),  0);
        check("async_dur",       longint'(dur),       0);
        repeat (3) cycle(0);
        rst = 1'b1;
        for (int i = 0; i < WIN; i++) begin
            cycle((i % 2 == 0) ? 5000 : -5000);
            if (i == WIN - 2) check("refill_valid_lo", longint'(env_valid), 0);
            if (i == WIN - 1) check("refill_valid_hi", longint'(env_valid), 1);
        end

        // Random envelopes around the thresholds.
        for (int w = 0; w < 60; w++) begin
            int amp;
            amp = $urandom_range(3800, 5300);
            for (int i = 0; i < WIN; i++) begin
                longint s;
                s = $urandom_range(0, amp);
                if ($urandom_range(0, 1) == 1) s = -s;
                cycle(s);
            end
        end
        cycle(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/nfc_ask_demod.md
Name: nfc_ask_demod

Overview:
- Receive-side counterpart of the NFC channel stimulus. Accepts the sampled channel output, a 13.56 MHz carrier amplitude-modulated between two envelope levels, and recovers the modulating bit stream.
- Rectifies and peak-detects the carrier over fixed windows, slices the envelope with hysteresis and debounces the result.
- Reports the recovered level, a one-cycle edge strobe and the duration of each completed level, for the emulation bench to compare against the driven envelope.

Parameters:
- WIDTH, 25, width of signed fixed-point input sample (two's complement, same scaling as channel output).
- WINDOW, 64, clocks per peak-detect window; must be at least 2.
- THRESH_HI, 4600, envelope code at or above which slicer goes high.
- THRESH_LO, 4400, envelope code at or below which slicer goes low; must be less than THRESH_HI.
- DEBOUNCE, 2, consecutive windows the slicer must disagree with out_bit before out_bit changes; must be at least 1.
- CNT_W, 16, width of duration counter.

Ports:
- clk  input  1  emulation clock; one input sample per cycle.
- rst  input  1  asynchronous, active-low reset.
- v_in  input  WIDTH  signed channel output sample.
- env  output  WIDTH  latched peak magnitude of the last completed window (unsigned value, MSB always 0).
- env_valid  output  1  high once the first window has completed.
- out_bit  output  1  debounced recovered envelope bit.
- edge_stb  output  1  one-cycle pulse on every out_bit change.
- dur  output  CNT_W  number of windows the previous out_bit level lasted; valid when edge_stb is high.

Behaviour:
- Reset (rst low, async): all outputs 0, running max 0, window counter 0, debounce counter 0, duration counter 0. State = FILL.
- Rectify: mag = |v_in|. The most-negative input saturates to 2^(WIDTH-1)-1.
- Window counter runs 0..WINDOW-1 and wraps. On a non-last cycle: run_max = max(run_max, mag). On the last cycle (count = WINDOW-1):
  - env <= max(run_max, mag).
  - run_max <= 0.
  - Raise an internal win_done for one cycle.
  - Latency: env updates on the clock edge that samples the window's final input.
- State FILL: env_valid = 0, slicer and debounce inactive. On the first win_done, go to TRACK and set env_valid = 1 (same edge env latches).
- State TRACK: all evaluation happens only on cycles following win_done, using the newly latched env.
  - Slicer: slice = 1 if env >= THRESH_HI; slice = 0 if env <= THRESH_LO; otherwise slice holds its previous value. Initial slice = 0.
  - Debounce: if slice != out_bit, deb_cnt += 1, else deb_cnt = 0. When deb_cnt reaches DEBOUNCE:
    - toggle out_bit;
    - pulse edge_stb;
    - present dur = dur_cnt;
    - reset dur_cnt to DEBOUNCE (windows already spent in the new level);
    - clear deb_cnt.
  - dur_cnt: increments once per window evaluation when no edge occurs. Saturates at 2^CNT_W-1 and does not wrap.
- edge_stb is high for exactly one clock. dur holds its value until the next edge.
- A glitch shorter than DEBOUNCE windows produces no edge and does not reset dur_cnt.
- If the envelope is inside the hysteresis band for its entire duration, there is no change and no edge.
- Reset asserted mid-window or mid-debounce: everything clears immediately. After release, the block restarts in FILL and needs a full window before env_valid.
- No backpressure: edge_stb is fire-and-forget; the consumer must sample it in the same cycle.

Test Plan:
- Reset and fill: hold rst low for 5 cycles, release, drive constant v_in = 1000. Require:
  - env_valid = 0 for cycles 0..62;
  - env_valid = 1 and env = 1000 after the 64th sample;
  - out_bit = 0; no edge_stb.
- Rectify and peak: square wave ±5000 with a single -5200 sample mid-window. Require env = 5200 for that window and env = 5000 for the next window. Input -2^24 gives env = 2^24-1.
- Envelope modulation: carrier ±5000 for 10 windows, ±4000 for 10 windows, repeated.
  - First edge_stb (out_bit 0 -> 1) arrives after window 2 of the ±5000 block (DEBOUNCE = 2).
  - Each subsequent edge reports dur = 10.
- Hysteresis: amplitude steps 5000 -> 4500 -> 4300. Require:
  - out_bit stays 1 through the 4500 section;
  - out_bit falls 2 windows after 4300 begins.
- Glitch rejection: one window at ±4000 inside a long ±5000 run. Require no edge_stb, out_bit stays 1, and the next dur counts across the glitch.
- Reset mid-operation: assert rst while out_bit = 1 with deb_cnt = 1. Require all outputs 0 immediately (asynchronous) and a full 64-cycle fill before env_valid.
